// File: rtl/cell_stream_link_delay.sv
// cell_stream_link_delay
// Models the fibre link between adjacent cells. Packets arriving from the
// cell stream mux are timestamped with their due time and queued in order.
// The head is replayed onto the mux input once it is due and the minimum
// inter-packet gap has elapsed. Packets arriving at a full queue are
// dropped and counted.
module cell_stream_link_delay #(
  parameter int LATENCY   = 64,
  parameter int MIN_GAP   = 4,
  parameter int AW        = 3,
  parameter int TW        = 16,
  parameter int CROSS_DIR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stream_mux_valid,
  input  logic [1:0]    stream_mux_src,
  input  logic [31:0]   stream_out_header,
  input  logic [31:0]   stream_out_datax,
  input  logic [31:0]   stream_out_datay,
  input  logic [31:0]   stream_out_datas,
  output logic          stream_mux_strobe,
  output logic [1:0]    stream_mux_sel,
  output logic [31:0]   stream_in_header,
  output logic [31:0]   stream_in_datax,
  output logic [31:0]   stream_in_datay,
  output logic [31:0]   stream_in_datas,
  output logic [AW:0]   occupancy,
  output logic          overflow,
  output logic [15:0]   drop_count
);

  localparam int DEPTH = 1 << AW;

  // Occupancy value meaning "every slot in use".
  localparam logic [AW:0]   FULL_C    = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   OCC_ONE_C = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE_C = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] TS_ONE_C  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [TW-1:0] LAT_C     = TW'(LATENCY);
  // The gap counter holds the number of blocked cycles still to run after a pop.
  localparam logic [3:0]    GAP_LOAD_C = 4'(MIN_GAP - 1);
  // Crossing to the opposite direction swaps CCW and CW, which is bit 0 of the index.
  localparam logic [1:0]    SEL_XOR_C  = (CROSS_DIR != 0) ? 2'b01 : 2'b00;

  typedef struct packed {
    logic [1:0]    src;
    logic [31:0]   header;
    logic [31:0]   datax;
    logic [31:0]   datay;
    logic [31:0]   datas;
    logic [TW-1:0] due;
  } entry_t;

  // Queue storage (data path only, no reset needed; validity comes from count_q).
  entry_t mem_q [DEPTH];

  logic [TW-1:0] now_q, now_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [3:0]    gap_q, gap_d;
  logic          strobe_q, strobe_d;
  logic [1:0]    sel_q, sel_d;
  logic [31:0]   header_q, header_d;
  logic [31:0]   datax_q, datax_d;
  logic [31:0]   datay_q, datay_d;
  logic [31:0]   datas_q, datas_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;

  entry_t        head_s;
  entry_t        new_entry_s;
  logic [TW-1:0] age_s;
  logic          head_due_s;
  logic          pop_s;
  logic          full_s;
  logic          accept_s;
  logic          drop_s;

  // Pop/push decision: head must be due (wrap-safe age test) and the gap expired.
  always_comb begin
    head_s      = mem_q[rd_ptr_q];
    age_s       = now_q - head_s.due;
    head_due_s  = (age_s[TW-1] == 1'b0);
    pop_s       = (count_q != {(AW+1){1'b0}}) && head_due_s && (gap_q == 4'd0);
    full_s      = (count_q == FULL_C);
    // A full queue still takes a packet when a slot frees in the same cycle.
    accept_s    = stream_mux_valid && (!full_s || pop_s);
    drop_s      = stream_mux_valid && !accept_s;
    new_entry_s = '{src:    stream_mux_src,
                    header: stream_out_header,
                    datax:  stream_out_datax,
                    datay:  stream_out_datay,
                    datas:  stream_out_datas,
                    due:    now_q + LAT_C};
  end

  // Next-state for time base, pointers, occupancy and gap counter.
  always_comb begin
    now_d    = now_q + TS_ONE_C;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    gap_d    = gap_q;

    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE_C;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE_C;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({accept_s, pop_s})
      2'b10:   count_d = count_q + OCC_ONE_C;
      2'b01:   count_d = count_q - OCC_ONE_C;
      default: count_d = count_q;
    endcase

    if (pop_s) begin
      gap_d = GAP_LOAD_C;
    end else if (gap_q != 4'd0) begin
      gap_d = gap_q - 4'd1;
    end else begin
      gap_d = gap_q;
    end
  end

  // Next-state for the replay outputs; data holds between strobes.
  always_comb begin
    strobe_d = pop_s;
    sel_d    = sel_q;
    header_d = header_q;
    datax_d  = datax_q;
    datay_d  = datay_q;
    datas_d  = datas_q;
    if (pop_s) begin
      sel_d    = head_s.src ^ SEL_XOR_C;
      header_d = head_s.header;
      datax_d  = head_s.datax;
      datay_d  = head_s.datay;
      datas_d  = head_s.datas;
    end else begin
      sel_d    = sel_q;
      header_d = header_q;
    end
  end

  // Next-state for the sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop_s) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end else begin
        drop_d = drop_q;
      end
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      now_q      <= {TW{1'b0}};
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {(AW+1){1'b0}};
      gap_q      <= 4'd0;
      strobe_q   <= 1'b0;
      sel_q      <= 2'b00;
      header_q   <= 32'd0;
      datax_q    <= 32'd0;
      datay_q    <= 32'd0;
      datas_q    <= 32'd0;
      overflow_q <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      now_q      <= now_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      gap_q      <= gap_d;
      strobe_q   <= strobe_d;
      sel_q      <= sel_d;
      header_q   <= header_d;
      datax_q    <= datax_d;
      datay_q    <= datay_d;
      datas_q    <= datas_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Queue write port; an accepted packet lands in the tail slot.
  always_ff @(posedge clk) begin
    if (rst_n && accept_s) begin
      mem_q[wr_ptr_q] <= new_entry_s;
    end
  end

  assign stream_mux_strobe = strobe_q;
  assign stream_mux_sel    = sel_q;
  assign stream_in_header  = header_q;
  assign stream_in_datax   = datax_q;
  assign stream_in_datay   = datay_q;
  assign stream_in_datas   = datas_q;
  assign occupancy         = count_q;
  assign overflow          = overflow_q;
  assign drop_count        = drop_q;

endmodule

// File: tb/tb_cell_stream_link_delay.sv
// Bench for cell_stream_link_delay. Two instances share the stimulus: one
// with default parameters, one with CROSS_DIR=1. The reference model keeps
// a queue of accepted packets, each tagged with its absolute strobe cycle
// max(push+LATENCY, previous strobe+MIN_GAP).
module tb_cell_stream_link_delay;

  localparam int LAT   = 64;
  localparam int GAP   = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [1:0]  src;
  logic [31:0] hdr, dx, dy, ds;

  logic        o_strobe, x_strobe;
  logic [1:0]  o_sel, x_sel;
  logic [31:0] o_h, o_x, o_y, o_s, x_h, x_x, x_y, x_s;
  logic [AW:0] o_occ, x_occ;
  logic        o_ovf, x_ovf;
  logic [15:0] o_drop, x_drop;

  always #5 clk = ~clk;

  cell_stream_link_delay dut (
    .clk(clk), .rst_n(rst_n),
    .stream_mux_valid(valid), .stream_mux_src(src),
    .stream_out_header(hdr), .stream_out_datax(dx),
    .stream_out_datay(dy), .stream_out_datas(ds),
    .stream_mux_strobe(o_strobe), .stream_mux_sel(o_sel),
    .stream_in_header(o_h), .stream_in_datax(o_x),
    .stream_in_datay(o_y), .stream_in_datas(o_s),
    .occupancy(o_occ), .overflow(o_ovf), .drop_count(o_drop)
  );

  cell_stream_link_delay #(.CROSS_DIR(1)) dut_x (
    .clk(clk), .rst_n(rst_n),
    .stream_mux_valid(valid), .stream_mux_src(src),
    .stream_out_header(hdr), .stream_out_datax(dx),
    .stream_out_datay(dy), .stream_out_datas(ds),
    .stream_mux_strobe(x_strobe), .stream_mux_sel(x_sel),
    .stream_in_header(x_h), .stream_in_datax(x_x),
    .stream_in_datay(x_y), .stream_in_datas(x_s),
    .occupancy(x_occ), .overflow(x_ovf), .drop_count(x_drop)
  );

  typedef struct {
    logic [1:0]  src;
    logic [31:0] h, x, y, s;
    int          st;
  } pkt_t;

  pkt_t        q[$];
  int          t;        // DUT "now" at the upcoming edge, unwrapped
  int          last_st;
  bit          e_strobe, e_ovf;
  logic [1:0]  e_sel, e_selx;
  logic [31:0] e_h, e_x, e_y, e_s;
  int          e_drops;
  int          checks = 0;
  int          errors = 0;
  int          seen_t;   // edge at which the default DUT last strobed

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    q.delete();
    t = 0; last_st = -1000;
    e_strobe = 1'b0; e_ovf = 1'b0; e_drops = 0;
    e_sel = 2'b00; e_selx = 2'b00;
    e_h = 32'd0; e_x = 32'd0; e_y = 32'd0; e_s = 32'd0;
  endtask

  task automatic model_edge(input bit v, input logic [1:0] ps, input logic [31:0] ph,
                            input logic [31:0] px, input logic [31:0] py, input logic [31:0] pz);
    int  occ;
    bit  pop;
    pkt_t p;
    occ = q.size();
    pop = (occ > 0) && (q[0].st == t);
    e_strobe = pop;
    if (pop) begin
      e_sel = q[0].src; e_selx = q[0].src ^ 2'b01;
      e_h = q[0].h; e_x = q[0].x; e_y = q[0].y; e_s = q[0].s;
      void'(q.pop_front());
    end
    if (v) begin
      if (occ < DEPTH || pop) begin
        p.src = ps; p.h = ph; p.x = px; p.y = py; p.s = pz;
        p.st = (t + LAT > last_st + GAP) ? t + LAT : last_st + GAP;
        last_st = p.st;
        q.push_back(p);
      end else begin
        e_ovf = 1'b1;
        if (e_drops < 65535) e_drops++;
      end
    end
    t++;
  endtask

  task automatic compare_all();
    chk("strobe", 64'(o_strobe), 64'(e_strobe));
    chk("sel", 64'(o_sel), 64'(e_sel));
    chk("header", 64'(o_h), 64'(e_h));
    chk("datax", 64'(o_x), 64'(e_x));
    chk("datay", 64'(o_y), 64'(e_y));
    chk("datas", 64'(o_s), 64'(e_s));
    chk("occupancy", 64'(o_occ), 64'(q.size()));
    chk("overflow", 64'(o_ovf), 64'(e_ovf));
    chk("drop_count", 64'(o_drop), 64'(e_drops));
    chk("x_strobe", 64'(x_strobe), 64'(e_strobe));
    chk("x_sel", 64'(x_sel), 64'(e_selx));
    chk("x_header", 64'(x_h), 64'(e_h));
    chk("x_datas", 64'(x_s), 64'(e_s));
    chk("x_occupancy", 64'(x_occ), 64'(q.size()));
    chk("x_drop_count", 64'(x_drop), 64'(e_drops));
    if (o_strobe === 1'b1) seen_t = t - 1;
  endtask

  task automatic cycle(input bit v, input logic [1:0] ps, input logic [31:0] ph,
                       input logic [31:0] px, input logic [31:0] py, input logic [31:0] pz);
    valid = v; src = ps; hdr = ph; dx = px; dy = py; ds = pz;
    @(posedge clk);
    model_edge(v, ps, ph, px, py, pz);
    #1;
    compare_all();
  endtask

  task automatic push_rand(input logic [1:0] ps);
    cycle(1'b1, ps, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, $urandom);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rst_n = 1'b0;
      valid = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      compare_all();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; src = 2'b00;
    hdr = 32'd0; dx = 32'd0; dy = 32'd0; ds = 32'd0;
    seen_t = -1;
    model_reset();
    do_reset(2);

    // Single packet at t=10: strobe 64 cycles later.
    idle(10);
    seen_t = -1;
    cycle(1'b1, 2'd0, 32'hA5000001, 32'd1, 32'd2, 32'd3);
    idle(80);
    chk("lat_single", 64'(seen_t - 10), 64'(LAT));

    // Back-to-back packets: spaced by the minimum gap in input order.
    push_rand(2'd0); push_rand(2'd1); push_rand(2'd0);
    idle(90);

    // Every source index, 10 cycles apart, exercises both sel mappings.
    for (int k = 0; k < 4; k++) begin
      push_rand(2'(k));
      idle(9);
    end
    idle(80);

    // Ten consecutive packets into an 8-deep queue: last two dropped.
    for (int k = 0; k < 10; k++) push_rand(2'($urandom_range(0, 3)));
    chk("occ_peak", 64'(o_occ), 64'(DEPTH));
    chk("drops_burst", 64'(o_drop), 64'(2));
    idle(150);

    // Random traffic: sparse, then dense enough to overrun the queue.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 5) == 0) push_rand(2'($urandom_range(0, 3)));
      else idle(1);
    end
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 0) push_rand(2'($urandom_range(0, 3)));
      else idle(1);
    end
    idle(200);

    // Timestamp wrap: push at now=0xFFF0 so the due time wraps to 0x0030.
    while (t < 32'h0000FFF0) idle(1);
    seen_t = -1;
    push_rand(2'd3);
    idle(80);
    chk("lat_wrap", 64'(seen_t - 32'h0000FFF0), 64'(LAT));

    // Random traffic continuing across the wrap point.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) push_rand(2'($urandom_range(0, 3)));
      else idle(1);
    end

    // Reset mid-flight discards queued packets.
    push_rand(2'd0); push_rand(2'd1); push_rand(2'd2);
    idle(5);
    do_reset(1);
    seen_t = -1;
    idle(100);
    chk("no_strobe_after_rst", 64'(seen_t), 64'(-1));
    begin
      int mark;
      mark = t;
      push_rand(2'd1);
      idle(80);
      chk("lat_after_rst", 64'(seen_t - mark), 64'(LAT));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_stream_link_delay.md
Name: cell_stream_link_delay

Overview:
- Models the fibre link between adjacent cells.
- Consumes the parallel packet output of the cell stream mux (valid/src/header/datax/datay/datas) and replays each packet onto the mux's parallel input (strobe/sel/header/datax/datay/datas) after a fixed link latency.
- Enforces a minimum inter-packet gap so the downstream input serialisers are never overrun.
- Buffers packets in an in-order timestamped FIFO and reports overflow.

Parameters:
- LATENCY, 64: cycles from accepted input valid to output strobe (unblocked case); legal range 2..2^(TW-1)-1.
- MIN_GAP, 4: minimum cycles between successive output strobes; legal range 1..15.
- AW, 3: FIFO address width; depth = 2^AW entries.
- TW, 16: timestamp counter width.
- CROSS_DIR, 0: 0 gives sel = src; 1 gives sel = src with bit 0 inverted (CCW<->CW).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- stream_mux_valid  input  1  one-cycle packet strobe from mux
- stream_mux_src  input  2  source stream index (0 cell CCW, 1 cell CW, 2 BPM CCW, 3 BPM CW)
- stream_out_header  input  32  packet header
- stream_out_datax  input  32  packet X
- stream_out_datay  input  32  packet Y
- stream_out_datas  input  32  packet S
- stream_mux_strobe  output  1  one-cycle replay strobe
- stream_mux_sel  output  2  destination stream index
- stream_in_header  output  32  replayed header
- stream_in_datax  output  32  replayed X
- stream_in_datay  output  32  replayed Y
- stream_in_datas  output  32  replayed S
- occupancy  output  AW+1  FIFO entries held
- overflow  output  1  sticky; set on any dropped packet
- drop_count  output  16  dropped packets, saturating at 0xFFFF

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on rst_n.
- Reset state (cycle after rst_n sampled low):
  - all outputs 0; FIFO emptied; timestamp counter 0; gap counter 0.
  - A reset mid-operation discards queued packets without emitting them.
- Time base: free-running TW-bit counter "now", +1 per cycle, wraps.
- Push: on stream_mux_valid high at edge t, store {src, header, x, y, s, due = now + LATENCY mod 2^TW}.
  - Push is accepted if occupancy < 2^AW, or if a pop occurs in the same cycle.
  - Otherwise the packet is dropped: overflow <= 1, drop_count += 1 (saturating).
- Pop eligibility, evaluated each cycle, all three required:
  - FIFO not empty;
  - head due, i.e. MSB of (now - head.due) mod 2^TW == 0 (wrap-safe);
  - gap counter == 0.
- Pop action:
  - Register the head fields onto stream_in_*.
  - stream_mux_sel = src, or src^2'b01 when CROSS_DIR=1.
  - stream_mux_strobe = 1 for exactly one cycle.
  - Gap counter loads MIN_GAP-1, then decrements to 0 once per cycle.
- Data outputs hold their last value between strobes.
- Latency: an unblocked packet sampled at edge t strobes out at edge t+LATENCY.
- Packets blocked by gap or ordering strobe at the first eligible cycle after that. Order is strictly FIFO, never reordered.
- Simultaneous push and pop: both occur; occupancy unchanged; the full-and-pop case accepts the push.
- Empty FIFO with a push in the same cycle: no bypass. The earliest strobe is still at t+LATENCY.
- occupancy is updated registered, same edge as the push/pop.
- overflow and drop_count clear only on reset.

Test Plan:
- Single packet: src=0, header=0xA5000001, x=1, y=2, s=3, valid at cycle 10 with defaults -> one strobe at cycle 74, sel=0, fields identical; occupancy 1 during cycles 11..74, 0 from cycle 75.
- Back-to-back: valid on cycles 10, 11, 12 (src 0, 1, 0) -> strobes at cycles 74, 78, 82 in input order; sels 0, 1, 0.
- CROSS_DIR=1: src 0, 1, 2, 3 spaced 10 cycles apart -> sel 1, 0, 3, 2.
- Overflow: 10 valids on consecutive cycles, AW=3 -> first 8 replayed in order, last 2 dropped; overflow=1, drop_count=2, occupancy peaks at 8.
- Timestamp wrap: hold until now=0xFFF0, push one packet (due wraps to 0x0030) -> strobe exactly 64 cycles later.
- Reset mid-flight: 3 packets queued, rst_n low for 1 cycle -> no strobes afterwards; occupancy=0, overflow=0, drop_count=0; a new packet then replays with latency 64.
